mini_cpu_core: RTL and testbench
================================

MINI_CPU_CORE -- requirements
Module: mini_cpu_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data/register width (legal 4..32).
REQ-002 The block SHALL have parameter NREG, default 4, register count (power of 2, 2..16); AW = log2(NREG).
REQ-003 The block SHALL have port clock  in  1  single rising-edge clock.
REQ-004 The block SHALL have port clr_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have port cmd_valid  in  1  command present.
REQ-006 The block SHALL have port cmd_ready  out  1  core can accept a command.
REQ-007 The block SHALL have port cmd_op  in  4  opcode.
REQ-008 The block SHALL have port cmd_rd  in  AW  destination register / first operand.
REQ-009 The block SHALL have port cmd_rs  in  AW  source register / second operand.
REQ-010 The block SHALL have port data_in  in  WIDTH  immediate for LOAD.
REQ-011 The block SHALL have ports rda_sel, rdb_sel  in  AW  read-port selects.
REQ-012 The block SHALL have ports rda_out, rdb_out  out  WIDTH  combinational reads of reg[rda_sel], reg[rdb_sel].
REQ-013 The block SHALL have ports zero, carry  out  1  registered ALU flags.
REQ-014 The block SHALL have ports done, err  out  1  completion pulse; err qualifies done.

Function
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL equal (state == IDLE).
REQ-016 The opcodes SHALL be: 0 NOP, 1 LOAD rd<=data_in, 2 MOV rd<=rs, 3 ADD rd<=rd+rs, 4 SUB rd<=rd-rs, 5 AND, 6 OR, 7 XOR (rd<=rd op rs), 8 NOT rd<=~rs, 9 SHL rd<=rs<<1, 10 SHR rd<=rs>>1 (logical), 11 MUL rd<=low WIDTH bits of rd*rs (unsigned), 12 CLR rd<=0, 13 CLRALL all regs<=0, 14-15 illegal.
REQ-017 Every opcode except MUL SHALL execute single-cycle: the register write and flag update occur on the accepting edge; the FSM stays in IDLE.
REQ-018 MUL SHALL latch its operands on the accepting edge, enter state MUL, run WIDTH shift-add iterations (one per cycle), write rd on edge accept+WIDTH, then return to IDLE.
REQ-019 done SHALL be a 1-cycle pulse in the cycle after the write edge (single-cycle ops: the cycle after accept; MUL: the cycle after edge accept+WIDTH); NOP also pulses done.
REQ-020 Back-to-back single-cycle commands SHALL be accepted on consecutive edges with no bubble.
REQ-021 During MUL cmd_ready SHALL be 0 and cmd_valid SHALL be ignored; a held command SHALL be accepted on the first edge after cmd_ready returns to 1.
REQ-022 zero SHALL be set to (result == 0) by ADD, SUB, AND, OR, XOR, NOT, SHL, SHR and MUL; NOP, LOAD, MOV, CLR, CLRALL and illegal opcodes SHALL leave both flags unchanged.
REQ-023 carry SHALL be set as follows: ADD carry-out; SUB borrow (rd < rs unsigned); SHL the bit shifted out of the MSB; SHR the bit shifted out of the LSB; MUL 1 if any high product bit is nonzero; logic ops clear it to 0.
REQ-024 When rd == rs, operands SHALL use the pre-write value (e.g. ADD r1,r1 doubles r1).
REQ-025 Read ports SHALL reflect the new value in the cycle after the write edge; no bypass is required.
REQ-026 Illegal opcodes SHALL leave registers and flags unchanged and SHALL pulse done together with err=1; err SHALL be 0 whenever done is 0 or the opcode is legal.

Reset
REQ-027 While clr_n is 0 (asynchronous assertion): all registers 0, zero=0, carry=0, done=0, err=0, state IDLE, MUL counter 0, cmd_ready=1.
REQ-028 Reset during MUL SHALL abort the operation with no write and no done pulse.
REQ-029 Reset release SHALL be synchronous to clock; the first command is acceptable on the first edge with clr_n=1.

Verification (WIDTH=8, NREG=4)
REQ-030 The bench SHALL cover: LOAD r0=0xF0, LOAD r1=0x20, ADD r0,r1 -> r0=0x10, carry=1, zero=0, one done per command, no bubbles.
REQ-031 The bench SHALL cover: r2=r3=0x05, SUB r2,r3 -> r2=0x00, zero=1, carry=0; then r2=0x03, SUB r2,r3 -> r2=0xFE, carry=1.
REQ-032 The bench SHALL cover: r0=0x0C, r1=0x0B, MUL r0,r1 -> r0=0x84 written at accept+8, cmd_ready low 8 cycles, carry=0; 0x10*0x10 -> 0x00, zero=1, carry=1.
REQ-033 The bench SHALL cover: a LOAD held valid during MUL -> not accepted until cmd_ready=1, then executed exactly once.
REQ-034 The bench SHALL cover: clr_n pulsed low 3 cycles into MUL -> all regs 0, flags 0, cmd_ready=1, no done.
REQ-035 The bench SHALL cover: opcode 14 -> done=1 and err=1 for one cycle, registers and flags unchanged; SHL of 0x81 -> 0x02, carry=1.

Source files
------------

// File: rtl/mini_cpu_core.sv
// mini_cpu_core: register-file CPU core with single-cycle ALU ops and a multi-cycle shift-add multiplier
// Opcodes other than MUL execute on the accepting edge; MUL occupies the core for WIDTH cycles.
module mini_cpu_core #(
   parameter int WIDTH = 8,
   parameter int NREG  = 4,
   localparam int AW   = $clog2(NREG)
) (
   input  logic             clock,
   input  logic             clr_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [AW-1:0]    cmd_rd,
   input  logic [AW-1:0]    cmd_rs,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AW-1:0]    rda_sel,
   input  logic [AW-1:0]    rdb_sel,
   output logic [WIDTH-1:0] rda_out,
   output logic [WIDTH-1:0] rdb_out,
   output logic             zero,
   output logic             carry,
   output logic             done,
   output logic             err
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic {S_IDLE, S_MUL} state_t;
   state_t             state;
   logic [WIDTH-1:0]   regs [NREG];
   logic [WIDTH-1:0]   a, b, res;
   logic               cy, wr, fl, illegal;
   logic [2*WIDTH-1:0] mcand, prod, prod_nx;
   logic [WIDTH-1:0]   mplier;
   logic [AW-1:0]      mrd;
   logic [CW-1:0]      cnt;
   assign cmd_ready = (state == S_IDLE);
   assign rda_out   = regs[rda_sel];
   assign rdb_out   = regs[rdb_sel];
   assign a         = regs[cmd_rd];
   assign b         = regs[cmd_rs];
   assign illegal   = (cmd_op[3:1] == 3'b111);
   assign prod_nx   = prod + (mplier[0] ? mcand : '0);
   always_comb begin
      res = '0;
      cy  = 1'b0;
      wr  = 1'b0;
      fl  = 1'b0;
      case (cmd_op)
         4'd1:    begin res = data_in; wr = 1'b1; end
         4'd2:    begin res = b; wr = 1'b1; end
         4'd3:    begin {cy, res} = {1'b0, a} + {1'b0, b}; wr = 1'b1; fl = 1'b1; end
         4'd4:    begin {cy, res} = {1'b0, a} - {1'b0, b}; wr = 1'b1; fl = 1'b1; end
         4'd5:    begin res = a & b; wr = 1'b1; fl = 1'b1; end
         4'd6:    begin res = a | b; wr = 1'b1; fl = 1'b1; end
         4'd7:    begin res = a ^ b; wr = 1'b1; fl = 1'b1; end
         4'd8:    begin res = ~b; wr = 1'b1; fl = 1'b1; end
         4'd9:    begin {cy, res} = {b, 1'b0}; wr = 1'b1; fl = 1'b1; end
         4'd10:   begin {res, cy} = {1'b0, b}; wr = 1'b1; fl = 1'b1; end
         4'd12:   wr = 1'b1;
         default: ;
      endcase
   end
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
         zero   <= 1'b0;
         carry  <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         mrd    <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (state == S_IDLE) begin
            if (cmd_valid) begin
               if (cmd_op == 4'd11) begin
                  state  <= S_MUL;
                  cnt    <= '0;
                  prod   <= '0;
                  mcand  <= {{WIDTH{1'b0}}, a};
                  mplier <= b;
                  mrd    <= cmd_rd;
               end else begin
                  done <= 1'b1;
                  err  <= illegal;
                  if (cmd_op == 4'd13) for (int i = 0; i < NREG; i++) regs[i] <= '0;
                  else if (wr) regs[cmd_rd] <= res;
                  if (fl) begin
                     zero  <= (res == '0);
                     carry <= cy;
                  end
               end
            end
         end else begin
            // one shift-add step per cycle; the last step commits the product
            prod   <= prod_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               regs[mrd] <= prod_nx[WIDTH-1:0];
               zero      <= (prod_nx[WIDTH-1:0] == '0);
               carry     <= |prod_nx[2*WIDTH-1:WIDTH];
               done      <= 1'b1;
               state     <= S_IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_mini_cpu_core.sv
// tb_mini_cpu_core: directed test of mini_cpu_core (WIDTH=8, NREG=4)
// Commands are driven 1ns after a rising edge and results are observed 1ns after the following edge.
module tb_mini_cpu_core;
   logic       clock = 1'b0;
   logic       clr_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = 4'd0;
   logic [1:0] cmd_rd = 2'd0, cmd_rs = 2'd0;
   logic [7:0] data_in = 8'd0;
   logic [1:0] rda_sel = 2'd0, rdb_sel = 2'd0;
   logic [7:0] rda_out, rdb_out;
   logic       zero, carry, done, err;
   int checks = 0;
   int errors = 0;
   mini_cpu_core #(.WIDTH(8), .NREG(4)) dut (
      .clock(clock), .clr_n(clr_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .data_in(data_in),
      .rda_sel(rda_sel), .rdb_sel(rdb_sel), .rda_out(rda_out), .rdb_out(rdb_out),
      .zero(zero), .carry(carry), .done(done), .err(err)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic reg_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
      rda_sel = sel;
      rdb_sel = sel;
      #1;
      chk({tag, "_a"}, rda_out, exp);
      chk({tag, "_b"}, rdb_out, exp);
   endtask
   task automatic flags(input string tag, input logic z, input logic c);
      chk({tag, "_zero"}, 8'(zero), 8'(z));
      chk({tag, "_carry"}, 8'(carry), 8'(c));
   endtask
   task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_rd = rd;
      cmd_rs = rs;
      data_in = d;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
   endtask
   task automatic step_done(input string tag);
      chk({tag, "_done"}, 8'(done), 8'd1);
      chk({tag, "_err"}, 8'(err), 8'd0);
   endtask
   initial begin
      #2;
      chk("rst_ready", 8'(cmd_ready), 8'd1);
      chk("rst_done", 8'(done), 8'd0);
      flags("rst", 1'b0, 1'b0);
      reg_chk("rst_r0", 2'd0, 8'h00);
      @(negedge clock);
      clr_n = 1'b1;
      @(posedge clock);
      #1;
      // ADD with carry-out, three commands back to back
      issue(4'd1, 2'd0, 2'd0, 8'hF0); step_done("ld_r0");
      issue(4'd1, 2'd1, 2'd0, 8'h20); step_done("ld_r1");
      issue(4'd3, 2'd0, 2'd1, 8'h00); step_done("add");
      reg_chk("add_r0", 2'd0, 8'h10);
      flags("add", 1'b0, 1'b1);
      // SUB to zero, then SUB with borrow
      issue(4'd1, 2'd2, 2'd0, 8'h05);
      issue(4'd1, 2'd3, 2'd0, 8'h05);
      issue(4'd4, 2'd2, 2'd3, 8'h00); step_done("sub0");
      reg_chk("sub0_r2", 2'd2, 8'h00);
      flags("sub0", 1'b1, 1'b0);
      issue(4'd1, 2'd2, 2'd0, 8'h03);
      issue(4'd4, 2'd2, 2'd3, 8'h00); step_done("subb");
      reg_chk("subb_r2", 2'd2, 8'hFE);
      flags("subb", 1'b0, 1'b1);
      // MUL 0x0C*0x0B: busy for 8 cycles, result 0x84
      issue(4'd1, 2'd0, 2'd0, 8'h0C);
      issue(4'd1, 2'd1, 2'd0, 8'h0B);
      issue(4'd11, 2'd0, 2'd1, 8'h00);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("mul_busy%0d", i), 8'(cmd_ready), 8'd0);
         chk($sformatf("mul_nodone%0d", i), 8'(done), 8'd0);
         reg_chk($sformatf("mul_r0_%0d", i), 2'd0, 8'h0C);
         @(posedge clock);
         #1;
      end
      chk("mul_busy7", 8'(cmd_ready), 8'd0);
      chk("mul_nodone7", 8'(done), 8'd0);
      @(posedge clock);
      #1;
      step_done("mul");
      chk("mul_ready", 8'(cmd_ready), 8'd1);
      reg_chk("mul_r0", 2'd0, 8'h84);
      flags("mul", 1'b0, 1'b0);
      // MUL 0x10*0x10 overflows to zero
      issue(4'd1, 2'd0, 2'd0, 8'h10);
      issue(4'd1, 2'd1, 2'd0, 8'h10);
      issue(4'd11, 2'd0, 2'd1, 8'h00);
      repeat (8) @(posedge clock);
      #1;
      step_done("mulov");
      reg_chk("mulov_r0", 2'd0, 8'h00);
      flags("mulov", 1'b1, 1'b1);
      // LOAD held valid during MUL 0x07*0x03
      issue(4'd1, 2'd2, 2'd0, 8'h07);
      issue(4'd1, 2'd3, 2'd0, 8'h03);
      issue(4'd11, 2'd2, 2'd3, 8'h00);
      cmd_valid = 1'b1;
      cmd_op = 4'd1;
      cmd_rd = 2'd1;
      data_in = 8'h5A;
      repeat (7) @(posedge clock);
      #1;
      reg_chk("hold_r1_busy", 2'd1, 8'h10);
      @(posedge clock);
      #1;
      step_done("hold_mul");
      reg_chk("hold_r2", 2'd2, 8'h15);
      reg_chk("hold_r1_notyet", 2'd1, 8'h10);
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      step_done("hold_ld");
      reg_chk("hold_r1", 2'd1, 8'h5A);
      @(posedge clock);
      #1;
      chk("hold_once", 8'(done), 8'd0);
      // illegal opcode leaves state alone
      issue(4'd7, 2'd3, 2'd3, 8'h00);
      flags("xor", 1'b1, 1'b0);
      issue(4'd14, 2'd1, 2'd2, 8'hAA);
      chk("ill_done", 8'(done), 8'd1);
      chk("ill_err", 8'(err), 8'd1);
      reg_chk("ill_r1", 2'd1, 8'h5A);
      reg_chk("ill_r2", 2'd2, 8'h15);
      flags("ill", 1'b1, 1'b0);
      @(posedge clock);
      #1;
      chk("ill_done_end", 8'(done), 8'd0);
      chk("ill_err_end", 8'(err), 8'd0);
      // SHL 0x81
      issue(4'd1, 2'd0, 2'd0, 8'h81);
      issue(4'd9, 2'd1, 2'd0, 8'h00); step_done("shl");
      reg_chk("shl_r1", 2'd1, 8'h02);
      flags("shl", 1'b0, 1'b1);
      // reset three cycles into a MUL
      issue(4'd11, 2'd2, 2'd3, 8'h00);
      repeat (3) @(posedge clock);
      #1;
      chk("pre_rst_ready", 8'(cmd_ready), 8'd0);
      clr_n = 1'b0;
      #1;
      chk("mrst_ready", 8'(cmd_ready), 8'd1);
      flags("mrst", 1'b0, 1'b0);
      reg_chk("mrst_r0", 2'd0, 8'h00);
      reg_chk("mrst_r1", 2'd1, 8'h00);
      reg_chk("mrst_r2", 2'd2, 8'h00);
      reg_chk("mrst_r3", 2'd3, 8'h00);
      @(negedge clock);
      clr_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clock);
         #1;
         chk($sformatf("mrst_nodone%0d", i), 8'(done), 8'd0);
      end
      reg_chk("mrst_r2_after", 2'd2, 8'h00);
      // post-reset command and rd==rs operand use
      issue(4'd1, 2'd1, 2'd0, 8'h21); step_done("post_ld");
      issue(4'd3, 2'd1, 2'd1, 8'h00); step_done("dbl");
      reg_chk("dbl_r1", 2'd1, 8'h42);
      flags("dbl", 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
